// File: rtl/alu_muldiv_seq_pkg.sv
// alu_muldiv_seq_pkg: op codes and sequencer state encoding shared by the MULT/DIV unit.
package alu_muldiv_seq_pkg;
   localparam logic [1:0] MD_OP_MULT = 2'b01;
   localparam logic [1:0] MD_OP_DIV  = 2'b10;
   typedef enum logic [1:0] {MD_IDLE, MD_RUN, MD_FIX} md_state_t;
endpackage

// File: rtl/alu_muldiv_seq_step.sv
// alu_muldiv_seq_step: one radix-2 iteration, shift-add (MULT) or restoring trial-subtract (DIV) on {acc, operand}.
module alu_muldiv_seq_step #(
   parameter int W = 16
) (
   input  logic           is_div,
   input  logic [2*W-1:0] acc,
   input  logic [W-1:0]   opnd,
   output logic [2*W-1:0] nxt
);
   logic [W:0]   sum;
   logic [W:0]   rs;
   logic [W-1:0] df;
   logic         ge;
   always_comb begin
      sum = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, opnd} : '0);
      rs  = {acc[2*W-1:W], acc[W-1]};
      ge  = rs >= {1'b0, opnd};
      // low W bits of the difference are exact whenever the subtract is kept
      df  = rs[W-1:0] - opnd;
      nxt = is_div ? {ge ? df : rs[W-1:0], acc[W-2:0], ge} : {sum, acc[W-1:1]};
   end
endmodule

// File: rtl/alu_muldiv_seq.sv
// alu_muldiv_seq: multi-cycle signed MULT/DIV sequencer owning the HI/LO register pair.
module alu_muldiv_seq
   import alu_muldiv_seq_pkg::*;
#(
   parameter int DATA_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [1:0]            op,
   input  logic [DATA_WIDTH-1:0] in1,
   input  logic [DATA_WIDTH-1:0] in2,
   input  logic                  wr_hi,
   input  logic                  wr_lo,
   input  logic [DATA_WIDTH-1:0] wdata,
   output logic                  busy,
   output logic                  done,
   output logic                  div_zero,
   output logic [DATA_WIDTH-1:0] hi,
   output logic [DATA_WIDTH-1:0] lo
);
   localparam int W  = DATA_WIDTH;
   localparam int CW = $clog2(W);
   md_state_t      state, state_nx;
   logic [CW-1:0]  cnt;
   logic [2*W-1:0] acc, acc_nx, prod;
   logic [W-1:0]   m, a1, a2, q, r;
   logic           s1, s2, is_div, dz, accept, zero;
   alu_muldiv_seq_step #(.W(W)) u_step (
      .is_div(is_div),
      .acc   (acc),
      .opnd  (m),
      .nxt   (acc_nx)
   );
   always_comb begin
      accept   = state == MD_IDLE && start && (op == MD_OP_MULT || op == MD_OP_DIV);
      zero     = op == MD_OP_DIV && in2 == '0;
      state_nx = state == MD_IDLE ? (accept ? (zero ? MD_FIX : MD_RUN) : MD_IDLE) :
                 state == MD_RUN  ? (cnt == CW'(W-1) ? MD_FIX : MD_RUN) : MD_IDLE;
      a1       = in1[W-1] ? -in1 : in1;
      a2       = in2[W-1] ? -in2 : in2;
      prod     = (s1 ^ s2) ? -acc : acc;
      q        = (s1 ^ s2) ? -acc[W-1:0] : acc[W-1:0];
      r        = s1 ? -acc[2*W-1:W] : acc[2*W-1:W];
      busy     = state != MD_IDLE;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= MD_IDLE;
         done     <= 1'b0;
         div_zero <= 1'b0;
         hi       <= '0;
         lo       <= '0;
      end else begin
         state <= state_nx;
         done  <= state == MD_FIX;
         if (accept) begin
            s1       <= in1[W-1];
            s2       <= in2[W-1];
            is_div   <= op == MD_OP_DIV;
            dz       <= zero;
            div_zero <= zero;
            cnt      <= '0;
            acc      <= {{W{1'b0}}, op == MD_OP_DIV ? a1 : a2};
            m        <= op == MD_OP_DIV ? a2 : a1;
         end
         if (state == MD_RUN) begin
            acc <= acc_nx;
            cnt <= cnt + 1'b1;
         end
         if (state == MD_IDLE && wr_hi) hi <= wdata;
         if (state == MD_IDLE && wr_lo) lo <= wdata;
         // divide-by-zero passes through FIX without touching hi/lo
         if (state == MD_FIX && !dz) {hi, lo} <= is_div ? {r, q} : prod;
      end
   end
endmodule
